// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- iterative radix-2 multiply/divide sequencer that owns HI/LO.
//
// Accepts MULT/MULTU/DIV/DIVU from the X stage. Each op runs WIDTH shift
// iterations on operand magnitudes (RUN), then applies sign correction and
// writes HI/LO (FIX). A new mult/div or an MFHI/MFLO arriving in X while an op
// is in flight raises a combinational stall.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, a multiply leaves RUN as soon as the remaining multiplier
//   bits are all zero. FIX then realigns the accumulator with one barrel
//   shift. Results are identical in both builds; only latency differs.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   mult/div op present in X this cycle
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a        in   rs: multiplicand / dividend
//   b        in   rt: multiplier / divisor
//   hilo_rd  in   MFHI/MFLO present in X this cycle
//   cancel   in   X-stage flush, aborts any running op
//   busy     out  op in progress (RUN or FIX)
//   done     out  one-cycle pulse after HI/LO update
//   stall    out  combinational, busy & (start | hilo_rd)
//   hi, lo   out  HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_r, state_next_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   opnd_r;     // multiplicand (mult) or divisor (div) magnitude
    logic [WIDTH-1:0]   mplier_r;   // remaining multiplier bits
    logic [2*WIDTH-1:0] acc_r;      // product, or remainder:quotient
    logic               is_div_r, neg_res_r, neg_rem_r, div_zero_r;
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               load_s, step_s, write_s, last_s;
    logic [WIDTH:0]     mul_sum_s, rem_sh_s, trial_s;
    logic [WIDTH-1:0]   mplier_step_s;
    logic [2*WIDTH-1:0] acc_step_s, prod_s;
    logic [WIDTH-1:0]   hi_fix_s, lo_fix_s;
    logic               sign_a_s, sign_b_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        return sgn ? neg_w(v) : v;
    endfunction

    // Operand sign flags: only signed ops (op[0] == 0) look at the MSB.
    always_comb begin
        sign_a_s = ~op[0] & a[WIDTH-1];
        sign_b_s = ~op[0] & b[WIDTH-1];
    end

    // One shift/add or shift/subtract iteration on the current accumulator.
    always_comb begin
        mul_sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + (mplier_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mplier_step_s = {1'b0, mplier_r[WIDTH-1:1]};
        // Remainder shifted left with the next dividend bit from the quotient half.
        rem_sh_s      = acc_r[2*WIDTH-1:WIDTH-1];
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
        trial_s       = rem_sh_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!trial_s[WIDTH]) begin
                acc_step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Iteration that ends RUN.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        last_s = (cnt_r == CNT_ONE) | (~is_div_r & (mplier_step_s == {WIDTH{1'b0}}));
`else
        last_s = (cnt_r == CNT_ONE);
`endif
    end

    // Sign correction and HI/LO values written in FIX.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        // Skipped iterations would only have shifted zeros in from the top.
        prod_s = acc_r >> cnt_r;
`else
        prod_s = acc_r;
`endif
        if (neg_res_r) begin
            prod_s = ~prod_s + ONE_2W;
        end else begin
            prod_s = prod_s;
        end
        if (is_div_r) begin
            hi_fix_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            if (div_zero_r) begin
                lo_fix_s = {WIDTH{1'b1}};
            end else begin
                lo_fix_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            end
        end else begin
            hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_s[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; cancel aborts RUN and FIX.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !cancel) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_next_s = ST_IDLE;
                end else if (last_s) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes.
    always_comb begin
        load_s  = 1'b0;
        step_s  = 1'b0;
        write_s = 1'b0;
        case (state_r)
            ST_IDLE: load_s  = start & ~cancel;
            ST_RUN:  step_s  = ~cancel;
            ST_FIX:  write_s = ~cancel;
            default: begin
                load_s  = 1'b0;
                step_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    // Datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= {CW{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= write_s;
            if (load_s) begin
                cnt_r      <= CNT_LOAD;
                is_div_r   <= op[1];
                neg_res_r  <= sign_a_s ^ sign_b_s;
                neg_rem_r  <= sign_a_s;
                div_zero_r <= (b == {WIDTH{1'b0}});
                if (op[1]) begin
                    opnd_r   <= magnitude(b, sign_b_s);
                    mplier_r <= {WIDTH{1'b0}};
                    acc_r    <= {{WIDTH{1'b0}}, magnitude(a, sign_a_s)};
                end else begin
                    opnd_r   <= magnitude(a, sign_a_s);
                    mplier_r <= magnitude(b, sign_b_s);
                    acc_r    <= {(2*WIDTH){1'b0}};
                end
            end else if (step_s) begin
                cnt_r    <= cnt_r - CNT_ONE;
                mplier_r <= mplier_step_s;
                acc_r    <= acc_step_s;
            end else if (write_s) begin
                hi_r <= hi_fix_s;
                lo_r <= lo_fix_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = busy_r & (start | hilo_rd);

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the shared HI/LO register pair and a radix-2 shift/add-subtract engine, and accepts MULT, MULTU, DIV and DIVU from the X stage. It raises a pipeline stall when a new mult/div op or an MFHI/MFLO reaches X while an operation is still running. It sits beside the ALU in X, and its `stall` output is ORed into the hazard unit's D/IF stall.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  a MULT/MULTU/DIV/DIVU is in X this cycle (`Signal`).
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand: multiplicand, or dividend.
- `b`  in  WIDTH  rt operand: multiplier, or divisor.
- `hilo_rd`  in  1  an MFHI/MFLO is in X this cycle.
- `cancel`  in  1  X-stage flush; aborts any running op.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when HI/LO have been updated.
- `stall`  out  1  combinational; hold D/IF and bubble X.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states are IDLE, RUN and FIX.
- IDLE:
  - If `start` and not `cancel`, capture the operand magnitudes and the sign flags, and load the iteration counter with `WIDTH`. Next state is RUN.
  - Magnitudes are the absolute values for MULT/DIV and the raw operands for MULTU/DIVU.
  - `start` with `cancel` in the same cycle is ignored.
- RUN: one iteration per cycle; the counter decrements each cycle, and the state goes to FIX when it reaches 0.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2·WIDTH accumulator. Then shift the accumulator and the multiplier right by 1.
  - Divide: shift the remainder:quotient pair left by 1. Trial-subtract the divisor from the remainder; if the result is non-negative, keep it and set the quotient LSB.
- FIX: apply sign correction, then write `hi`/`lo`.
  - MULT: negate the 2·WIDTH product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - Next state is IDLE, and `done` is asserted on the following cycle.
- Divide by zero (b = 0, DIV or DIVU): `lo` = all ones, `hi` = `a` unmodified. This is the natural result of the algorithm for DIVU; DIV is forced to the same result in FIX.
- DIV of −2^(WIDTH−1) by −1: `lo` = 0x80000000, `hi` = 0. No trap is raised.
- `busy` is high in RUN and FIX.
- `stall` = `busy` & (`start` | `hilo_rd`). While stalled, the X instruction is held and its `start` is not accepted until `busy` falls.
- `cancel` in RUN or FIX: next state is IDLE, `hi`/`lo` are unchanged, and `done` is not pulsed. `cancel` has priority over the FIX writeback.
- `reset` wins over everything: state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0. `stall` is therefore 0 after reset.

## Timing
- `start` is sampled in cycle 0.
- RUN occupies cycles 1..WIDTH, and FIX is cycle WIDTH+1.
- `hi`/`lo` are valid and `done` = 1 in cycle WIDTH+2. For WIDTH = 32 this is cycle 34.
- `busy` is high in cycles 1..WIDTH+1.
- An MFHI in cycle WIDTH+2 reads the new value with no stall.
- A new `start` is accepted in the cycle after `busy` falls, so throughput is one op per WIDTH+2 cycles.
- `hilo_rd` with `busy` = 0 never stalls. HI/LO reads see the registered values directly; there is no bypass from FIX.

## Configuration
- Macro: `MULDIV_EARLY_OUT_EN`.
- Defined: in multiply RUN, after an iteration that leaves the remaining multiplier bits all zero, go to FIX immediately. The accumulator is then realigned by the skipped shift count in FIX, using one barrel shift. Divide timing is unchanged.
- Undefined: every multiply takes exactly WIDTH RUN cycles, and no realignment logic is synthesized.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- MULTU, `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF, WIDTH = 32 → `done` in cycle 34, `hi` = 0xFFFFFFFE, `lo` = 0x00000001. `busy` is high in cycles 1–33.
- MULT with `a` = −3, `b` = 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. With `MULDIV_EARLY_OUT_EN` defined: 3 RUN cycles, `done` in cycle 5, same result.
- DIV −7/2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIVU 7/0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000007. DIV 0x80000000 / −1 → `lo` = 0x80000000, `hi` = 0.
- Start DIVU, then assert `hilo_rd` in cycles 5–34 → `stall` = 1 in cycles 5–33 and 0 in cycle 34, where `lo` already holds the result. A second `start` in cycle 10 also stalls until cycle 34.
- Start MULTU 2×3 after a completed op that left `hi`/`lo` = 0/6, then `cancel` in cycle 20 → IDLE in cycle 21, `busy` = 0, no `done`, `hi`/`lo` still 0/6. The same sequence with `reset` in cycle 20 instead → `hi` = `lo` = 0.
- `start` and `cancel` together in IDLE → no state change, `busy` stays 0.
